// File: rtl/oram_host_adapter_pkg.sv
// Shared encodings for the ORAM host adapter: core command codes, FSM states, counter sizing.
package oram_host_adapter_pkg;

    localparam int unsigned BECmdWidth = 2;
    localparam logic [BECmdWidth-1:0] BECMD_Update = 2'd0;
    localparam logic [BECmdWidth-1:0] BECMD_Read   = 2'd2;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StIssue = 3'd1,
        StWData = 3'd2,
        StRData = 3'd3,
        StResp  = 3'd4
    } state_e;

    // Keeps the beat counter at least one bit wide when a line is a single beat.
    function automatic int unsigned cnt_width(input int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/oram_line_beat_shifter.sv
// Line register that serializes a loaded line into beats (LSB beat first) or gathers beats into a
// line, plus the wrapping beat counter that flags the last beat.
module oram_line_beat_shifter
    import oram_host_adapter_pkg::*;
#(
    parameter int unsigned ORAMB    = 512,
    parameter int unsigned FEDWidth = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic [ORAMB-1:0]    line_i,
    input  logic                shift_i,
    input  logic                capture_i,
    input  logic [FEDWidth-1:0] beat_i,
    output logic [FEDWidth-1:0] beat_o,
    output logic [ORAMB-1:0]    line_o,
    output logic                last_o
);

    localparam int unsigned Beats = ORAMB / FEDWidth;
    localparam int unsigned CntW  = cnt_width(Beats);
    localparam logic [CntW-1:0] LastCnt = CntW'(Beats - 1);

    logic [ORAMB-1:0] line_q, line_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    // Both directions shift right: writes drain zeros in behind the beats, so a finished write
    // leaves an all-zero line; reads enter at the top so beat 0 ends up at the bottom.
    always_comb begin
        line_d = line_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            line_d = line_i;
            cnt_d  = '0;
        end else if (shift_i || capture_i) begin
            cnt_d  = (cnt_q == LastCnt) ? '0 : cnt_q + CntW'(1);
            line_d = line_q >> FEDWidth;
            if (capture_i) begin
                line_d = line_d | (ORAMB'(beat_i) << (ORAMB - FEDWidth));
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            line_q <= '0;
            cnt_q  <= '0;
        end else begin
            line_q <= line_d;
            cnt_q  <= cnt_d;
        end
    end

    assign beat_o = line_q[FEDWidth-1:0];
    assign line_o = line_q;
    assign last_o = (cnt_q == LastCnt);

endmodule

// File: rtl/oram_host_adapter.sv
// Host-side adapter for the TinyORAM core: one whole-line request in flight, split into beats.
// Optional ORAM_ADDR_CHECK_EN rejects block addresses >= NumValidBlock without touching the core.
module oram_host_adapter
    import oram_host_adapter_pkg::*;
#(
    parameter int unsigned ORAMB         = 512,
    parameter int unsigned ORAMU         = 32,
    parameter int unsigned FEDWidth      = 64,
    parameter int unsigned NumValidBlock = 8192
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  HostReqWrite,
    input  logic [ORAMU-1:0]      HostAddr,
    input  logic [ORAMB-1:0]      HostWData,
    input  logic                  HostReqValid,
    output logic                  HostReqReady,
    output logic [ORAMB-1:0]      HostRData,
    output logic                  HostRespErr,
    output logic                  HostRespValid,
    input  logic                  HostRespReady,
    output logic [BECmdWidth-1:0] Cmd,
    output logic [ORAMU-1:0]      PAddr,
    output logic                  CmdValid,
    input  logic                  CmdReady,
    output logic [FEDWidth-1:0]   DataIn,
    output logic                  DataInValid,
    input  logic                  DataInReady,
    input  logic [FEDWidth-1:0]   DataOut,
    input  logic                  DataOutValid,
    output logic                  DataOutReady
);

`ifdef ORAM_ADDR_CHECK_EN
    localparam bit AddrCheckEn = 1'b1;
`else
    localparam bit AddrCheckEn = 1'b0;
`endif
    localparam logic [ORAMU-1:0] NumValidAddr = ORAMU'(NumValidBlock);

    state_e           state_q, state_d;
    logic             write_q, write_d;
    logic [ORAMU-1:0] addr_q, addr_d;
    logic             err_q, err_d;

    logic                addr_bad;
    logic                load, shift, capture, last;
    logic [FEDWidth-1:0] beat;
    logic [ORAMB-1:0]    line;

    assign addr_bad = AddrCheckEn && (HostAddr >= NumValidAddr);

    always_comb begin
        state_d       = state_q;
        write_d       = write_q;
        addr_d        = addr_q;
        err_d         = err_q;
        load          = 1'b0;
        shift         = 1'b0;
        capture       = 1'b0;
        HostReqReady  = 1'b0;
        HostRespValid = 1'b0;
        CmdValid      = 1'b0;
        DataInValid   = 1'b0;
        DataOutReady  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Held low during reset so every output reads zero while Reset is high.
                HostReqReady = !Reset;
                if (HostReqValid) begin
                    load    = 1'b1;
                    write_d = HostReqWrite;
                    addr_d  = HostAddr;
                    err_d   = addr_bad;
                    state_d = addr_bad ? StResp : StIssue;
                end
            end
            StIssue: begin
                CmdValid = 1'b1;
                if (CmdReady) begin
                    state_d = write_q ? StWData : StRData;
                end
            end
            StWData: begin
                DataInValid = 1'b1;
                if (DataInReady) begin
                    shift = 1'b1;
                    if (last) state_d = StResp;
                end
            end
            StRData: begin
                DataOutReady = 1'b1;
                if (DataOutValid) begin
                    capture = 1'b1;
                    if (last) state_d = StResp;
                end
            end
            StResp: begin
                HostRespValid = 1'b1;
                if (HostRespReady) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= StIdle;
            write_q <= 1'b0;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    // Reads and rejected requests start from a zero line; writes start from the host line.
    oram_line_beat_shifter #(
        .ORAMB    (ORAMB),
        .FEDWidth (FEDWidth)
    ) u_shifter (
        .clk_i     (Clock),
        .rst_i     (Reset),
        .load_i    (load),
        .line_i    ((HostReqWrite && !addr_bad) ? HostWData : '0),
        .shift_i   (shift),
        .capture_i (capture),
        .beat_i    (DataOut),
        .beat_o    (beat),
        .line_o    (line),
        .last_o    (last)
    );

    assign Cmd         = CmdValid ? (write_q ? BECMD_Update : BECMD_Read) : '0;
    assign PAddr       = CmdValid ? addr_q : '0;
    assign DataIn      = DataInValid ? beat : '0;
    assign HostRData   = HostRespValid ? line : '0;
    assign HostRespErr = HostRespValid && err_q;

endmodule

// File: tb/tb_oram_host_adapter.sv
// Self-checking bench for oram_host_adapter: directed scenarios plus randomized requests against
// a queue-based core model; honours ORAM_ADDR_CHECK_EN when the design is built with it.
module tb_oram_host_adapter;
    import oram_host_adapter_pkg::*;

    localparam int unsigned ORAMB         = 512;
    localparam int unsigned ORAMU         = 32;
    localparam int unsigned FEDWidth      = 64;
    localparam int unsigned NumValidBlock = 8192;
    localparam int unsigned Beats         = ORAMB / FEDWidth;
    localparam int unsigned CW            = 640;
`ifdef ORAM_ADDR_CHECK_EN
    localparam bit AddrCheck = 1'b1;
`else
    localparam bit AddrCheck = 1'b0;
`endif

    logic                  Clock;
    logic                  Reset;
    logic                  HostReqWrite;
    logic [ORAMU-1:0]      HostAddr;
    logic [ORAMB-1:0]      HostWData;
    logic                  HostReqValid;
    logic                  HostReqReady;
    logic [ORAMB-1:0]      HostRData;
    logic                  HostRespErr;
    logic                  HostRespValid;
    logic                  HostRespReady;
    logic [BECmdWidth-1:0] Cmd;
    logic [ORAMU-1:0]      PAddr;
    logic                  CmdValid;
    logic                  CmdReady = 1'b0;
    logic [FEDWidth-1:0]   DataIn;
    logic                  DataInValid;
    logic                  DataInReady = 1'b0;
    logic [FEDWidth-1:0]   DataOut = '0;
    logic                  DataOutValid = 1'b0;
    logic                  DataOutReady;

    oram_host_adapter #(
        .ORAMB         (ORAMB),
        .ORAMU         (ORAMU),
        .FEDWidth      (FEDWidth),
        .NumValidBlock (NumValidBlock)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .HostReqWrite  (HostReqWrite),
        .HostAddr      (HostAddr),
        .HostWData     (HostWData),
        .HostReqValid  (HostReqValid),
        .HostReqReady  (HostReqReady),
        .HostRData     (HostRData),
        .HostRespErr   (HostRespErr),
        .HostRespValid (HostRespValid),
        .HostRespReady (HostRespReady),
        .Cmd           (Cmd),
        .PAddr         (PAddr),
        .CmdValid      (CmdValid),
        .CmdReady      (CmdReady),
        .DataIn        (DataIn),
        .DataInValid   (DataInValid),
        .DataInReady   (DataInReady),
        .DataOut       (DataOut),
        .DataOutValid  (DataOutValid),
        .DataOutReady  (DataOutReady)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Core model state: beats the core will return, beats it received, commands it accepted.
    logic [FEDWidth-1:0]         rd_src[$];
    logic [FEDWidth-1:0]         win_q[$];
    logic [BECmdWidth+ORAMU-1:0] cmd_log[$];
    int cmd_cnt  = 0;
    int dout_cnt = 0;
    int stab_err = 0;
    int cmd_mode = 2;   // 0 random, 1 stall, 2 always ready
    int din_mode = 2;   // 0 random, 1 toggle, 2 always ready
    int dout_mode = 2;  // 0 random, else present whenever a beat is queued
    bit hold_pend = 1'b0;
    logic [BECmdWidth+ORAMU-1:0] hold_v = '0;

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Handshakes observed mid-cycle take effect at the following rising edge.
    always @(negedge Clock) begin
        if (Reset) begin
            rd_src.delete();
            hold_pend = 1'b0;
        end else begin
            if (hold_pend && (!CmdValid || {Cmd, PAddr} !== hold_v)) stab_err++;
            hold_pend = CmdValid && !CmdReady;
            hold_v    = {Cmd, PAddr};
            if (CmdValid && CmdReady) begin
                cmd_cnt++;
                cmd_log.push_back({Cmd, PAddr});
            end
            if (DataInValid && DataInReady) win_q.push_back(DataIn);
            if (DataOutValid && DataOutReady) begin
                dout_cnt++;
                if (rd_src.size() > 0) void'(rd_src.pop_front());
            end
        end
    end

    always begin
        @(posedge Clock);
        #1;
        case (cmd_mode)
            0:       CmdReady = 1'($urandom_range(0, 1));
            1:       CmdReady = 1'b0;
            default: CmdReady = 1'b1;
        endcase
        case (din_mode)
            0:       DataInReady = 1'($urandom_range(0, 1));
            1:       DataInReady = ~DataInReady;
            default: DataInReady = 1'b1;
        endcase
        if (rd_src.size() > 0 && (dout_mode != 0 || $urandom_range(0, 1) == 1)) begin
            DataOutValid = 1'b1;
            DataOut      = rd_src[0];
        end else begin
            DataOutValid = 1'b0;
            DataOut      = {$urandom, $urandom};
        end
    end

    function automatic logic [CW-1:0] outs_no_ready();
        return CW'({HostRData, HostRespErr, HostRespValid, Cmd, PAddr, CmdValid, DataIn,
                    DataInValid, DataOutReady});
    endfunction

    function automatic logic [ORAMB-1:0] rand_line();
        logic [ORAMB-1:0] l;
        for (int i = 0; i < ORAMB / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic recover();
        HostReqValid  = 1'b0;
        HostRespReady = 1'b0;
        Reset         = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
    endtask

    // One request end to end; for reads, line is what the core returns beat by beat.
    task automatic run_req(input string tag, input bit wr, input logic [ORAMU-1:0] addr,
                           input logic [ORAMB-1:0] line, input int resp_delay,
                           input int cmd_hold, output int lat);
        bit               bad;
        bit               ok;
        int               n;
        int               c0;
        logic [ORAMB-1:0] exp_rd;
        logic [ORAMB-1:0] got;
        bad    = AddrCheck && (addr >= NumValidBlock);
        exp_rd = (wr || bad) ? '0 : line;
        lat    = -1;
        c0     = cmd_cnt;
        win_q.delete();
        if (!wr && !bad) begin
            for (int i = 0; i < Beats; i++) rd_src.push_back(line[i*FEDWidth +: FEDWidth]);
        end
        if (cmd_hold > 0) cmd_mode = 1;
        HostReqWrite = wr;
        HostAddr     = addr;
        HostWData    = line;
        HostReqValid = 1'b1;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 50) begin
            ok = HostReqReady;
            @(posedge Clock);
            #1;
            n++;
        end
        HostReqValid = 1'b0;
        chk({tag, "/accept"}, CW'(ok), CW'(1));
        if (!ok) begin
            recover();
            return;
        end
        chk({tag, "/cmdvalid_next"}, CW'(CmdValid), CW'(!bad));
        if (cmd_hold > 0) begin
            ok = 1'b1;
            for (int k = 0; k < cmd_hold; k++) begin
                ok = ok && CmdValid && (cmd_cnt == c0)
                     && (Cmd === (wr ? BECMD_Update : BECMD_Read)) && (PAddr === addr);
                @(posedge Clock);
                #1;
            end
            chk({tag, "/cmd_stall"}, CW'(ok), CW'(1));
            cmd_mode = 2;
        end
        n = 0;
        while (!HostRespValid && n < 2000) begin
            @(posedge Clock);
            #1;
            n++;
        end
        lat = n + 1;
        chk({tag, "/resp_valid"}, CW'(HostRespValid), CW'(1));
        if (!HostRespValid) begin
            recover();
            return;
        end
        chk({tag, "/err"}, CW'(HostRespErr), CW'(bad));
        chk({tag, "/rdata"}, CW'(HostRData), CW'(exp_rd));
        chk({tag, "/ncmd"}, CW'(cmd_cnt - c0), CW'(bad ? 0 : 1));
        if (!bad && cmd_log.size() > 0) begin
            chk({tag, "/cmd"}, CW'(cmd_log[$]),
                CW'({(wr ? BECMD_Update : BECMD_Read), addr}));
        end
        if (wr && !bad) begin
            got = '0;
            for (int i = 0; i < win_q.size() && i < Beats; i++) begin
                got[i*FEDWidth +: FEDWidth] = win_q[i];
            end
            chk({tag, "/nbeats"}, CW'(win_q.size()), CW'(Beats));
            chk({tag, "/wbeats"}, CW'(got), CW'(line));
        end else begin
            chk({tag, "/nbeats"}, CW'(win_q.size()), CW'(0));
        end
        chk({tag, "/src_left"}, CW'(rd_src.size()), CW'(0));
        // A new request waits alongside the pending response; it must not slip in early.
        c0           = cmd_cnt;
        ok           = 1'b1;
        HostReqValid = 1'b1;
        for (int k = 0; k < resp_delay; k++) begin
            ok = ok && HostRespValid && !HostReqReady && (HostRData === exp_rd)
                 && (HostRespErr === bad);
            @(posedge Clock);
            #1;
        end
        ok = ok && HostRespValid && !HostReqReady;
        HostRespReady = 1'b1;
        @(posedge Clock);
        #1;
        HostRespReady = 1'b0;
        chk({tag, "/no_bypass"}, CW'({HostReqReady, HostRespValid, CmdValid}), CW'(3'b100));
        HostReqValid = 1'b0;
        chk({tag, "/resp_hold"}, CW'(ok), CW'(1));
        chk({tag, "/hold_nocmd"}, CW'(cmd_cnt - c0), CW'(0));
    endtask

    initial begin
        int               lat;
        int               d0;
        int               n;
        bit               ok;
        logic [ORAMB-1:0] l;
        Reset         = 1'b1;
        HostReqWrite  = 1'b0;
        HostAddr      = '0;
        HostWData     = '0;
        HostReqValid  = 1'b0;
        HostRespReady = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        chk("reset/ready", CW'(HostReqReady), CW'(0));
        chk("reset/outputs", outs_no_ready(), '0);
        Reset = 1'b0;
        @(posedge Clock);
        #1;
        chk("idle/ready", CW'(HostReqReady), CW'(1));
        chk("idle/outputs", outs_no_ready(), '0);

        // Zero-stall core: response appears 2+Beats cycles after the accept cycle.
        run_req("lat_wr", 1'b1, 32'h22, rand_line(), 0, 0, lat);
        chk("lat_wr/cycles", CW'(lat), CW'(2 + Beats));
        run_req("lat_rd", 1'b0, 32'h23, rand_line(), 0, 0, lat);
        chk("lat_rd/cycles", CW'(lat), CW'(2 + Beats));

        for (int i = 0; i < Beats; i++) l[i*FEDWidth +: FEDWidth] = FEDWidth'(i);
        dout_mode = 0;
        run_req("rd_5", 1'b0, 32'h5, l, 1, 0, lat);

        for (int i = 0; i < Beats; i++) l[i*FEDWidth +: FEDWidth] = FEDWidth'(32'hA0 + i);
        din_mode = 1;
        run_req("wr_toggle", 1'b1, 32'h10, l, 1, 0, lat);
        din_mode = 2;

        run_req("cmd_stall", 1'b1, 32'h77, rand_line(), 0, 20, lat);
        chk("cmd_stall/stable", CW'(stab_err), CW'(0));

        run_req("resp_hold", 1'b0, 32'h1234, rand_line(), 10, 0, lat);

        // Reset lands after three of the read beats have been taken.
        l = rand_line();
        for (int i = 0; i < Beats; i++) rd_src.push_back(l[i*FEDWidth +: FEDWidth]);
        HostReqWrite = 1'b0;
        HostAddr     = 32'h33;
        HostReqValid = 1'b1;
        @(posedge Clock);
        #1;
        HostReqValid = 1'b0;
        d0 = dout_cnt;
        n  = 0;
        while ((dout_cnt - d0) < 3 && n < 200) begin
            @(posedge Clock);
            #1;
            n++;
        end
        chk("mid_reset/three_beats", CW'(dout_cnt - d0), CW'(3));
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        chk("mid_reset/ready", CW'(HostReqReady), CW'(0));
        chk("mid_reset/outputs", outs_no_ready(), '0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        @(posedge Clock);
        #1;
        chk("mid_reset/idle", CW'({HostReqReady, HostRespValid, CmdValid, DataOutReady}),
            CW'(4'b1000));
        run_req("after_reset", 1'b0, 32'h34, rand_line(), 0, 0, lat);

        run_req("addr_8192", 1'b0, 32'd8192, rand_line(), 1, 0, lat);
        run_req("addr_8192_wr", 1'b1, 32'd8192, rand_line(), 0, 0, lat);
        run_req("addr_8191", 1'b0, 32'd8191, rand_line(), 1, 0, lat);

        for (int t = 0; t < 40; t++) begin
            cmd_mode  = $urandom_range(0, 1) * 2;
            din_mode  = $urandom_range(0, 2);
            dout_mode = $urandom_range(0, 2);
            run_req($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)),
                    AddrCheck ? ORAMU'($urandom_range(0, 16383)) : ORAMU'($urandom),
                    rand_line(), $urandom_range(0, 3),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, lat);
        end
        cmd_mode = 2;
        ok = (stab_err == 0);
        chk("final/cmd_stable", CW'(ok), CW'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
